mul_booth_r4: RTL and testbench

- Multi-cycle radix-4 Booth multiplier for the EX stage; executes MIPS MULT/MULTU and produces the 64-bit {HI, LO} product.
- Companion to the stage's iterative divider, with the same handshake: `en` is held while the instruction sits in EX, and `done` low stalls the pipeline.
- Retires two multiplier bits per cycle. Result is available 19 cycles after acceptance.

---
 rtl/mul_booth_r4.sv | 125 ++++++++++++
 tb/tb_mul_booth_r4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_booth_r4.sv
// Radix-4 Booth multiplier for MULT/MULTU. Retires one Booth digit per cycle and
// writes the 64-bit {HI, LO} product 19 cycles after a request is accepted.

module mul_booth_r4_digit #(
    parameter int MW = 34,
    parameter int AW = 36
) (
    input  logic [2:0]    sel,
    input  logic [MW-1:0] m,
    output logic [AW-1:0] addend
);
    logic [AW-1:0] m1;
    logic [AW-1:0] m2;

    always_comb begin
        m1 = {{(AW-MW){m[MW-1]}}, m};
        m2 = {{(AW-MW-1){m[MW-1]}}, m, 1'b0};
        unique case (sel)
            3'b001, 3'b010: addend = m1;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m1;
            default:        addend = '0;
        endcase
    end
endmodule

module mul_booth_r4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             done
);
    localparam int XW      = WIDTH + 2;
    localparam int AW      = WIDTH + 4;
    localparam int PW      = AW + XW + 1;
    localparam int DIGITS  = XW / 2;
    localparam int COUNT_W = $clog2(DIGITS);

    typedef enum logic [1:0] {FREE, ON, END} state_t;

    typedef struct packed {
        logic             signed_op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state;
    req_t               req;
    req_t               last_req;
    logic               start;
    logic [XW-1:0]      m;
    logic [XW-1:0]      m_ext;
    logic [XW-1:0]      q_ext;
    logic [PW-1:0]      p;
    logic [PW-1:0]      p_next;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      acc;
    logic [COUNT_W-1:0] count;
    logic [2*WIDTH-1:0] result;

    assign req   = '{signed_op: signed_op, a: multiplicand, b: multiplier};
    // An identical re-issue reuses the held result instead of restarting.
    assign start = (state == FREE) && en && (req != last_req);
    assign done  = (state == FREE) && !start;

    assign m_ext = {{2{signed_op & multiplicand[WIDTH-1]}}, multiplicand};
    assign q_ext = {{2{signed_op & multiplier[WIDTH-1]}}, multiplier};

    mul_booth_r4_digit #(.MW(XW), .AW(AW)) u_digit (
        .sel    (p[2:0]),
        .m      (m),
        .addend (addend)
    );

    // Accumulate into the top AW bits, then arithmetic shift by one digit.
    always_comb begin
        acc    = p[PW-1 -: AW] + addend;
        p_next = {{2{acc[AW-1]}}, acc, p[PW-AW-1:2]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FREE;
            last_req <= '0;
            count    <= '0;
            result   <= '0;
            m        <= '0;
            p        <= '0;
        end else begin
            unique case (state)
                FREE: begin
                    if (start) begin
                        last_req <= req;
                        m        <= m_ext;
                        p        <= {{AW{1'b0}}, q_ext, 1'b0};
                        count    <= '0;
                        state    <= ON;
                    end
                end
                ON: begin
                    p     <= p_next;
                    count <= count + 1'b1;
                    if (count == COUNT_W'(DIGITS - 1))
                        state <= END;
                end
                END: begin
                    result <= p[2*WIDTH:1];
                    state  <= FREE;
                end
                default: state <= FREE;
            endcase
        end
    end

    assign product_hi = result[2*WIDTH-1:WIDTH];
    assign product_lo = result[WIDTH-1:0];
endmodule

// File: tb/tb_mul_booth_r4.sv
// Scoreboard bench for mul_booth_r4: stimulus queues expected products, a monitor
// checks them on every rising edge of done along with the stall length.

module tb_mul_booth_r4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             signed_op = 1'b0;
    logic [WIDTH-1:0] multiplicand = '0;
    logic [WIDTH-1:0] multiplier = '0;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
    logic             done;

    typedef struct {
        logic [63:0] prod;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    mul_booth_r4 #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .signed_op    (signed_op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{s & a[31]}}, a};
        eb = {{32{s & b[31]}}, b};
        return ea * eb;
    endfunction

    // Monitor: count stalled cycles, compare on each rising edge of done.
    initial begin
        int   low;
        logic prev;
        exp_t e;
        low  = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!done) begin
                low++;
            end else begin
                if (!prev) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check("product", {product_hi, product_lo}, e.prod);
                        if (e.len >= 0)
                            check("stall_cycles", 64'(low), 64'(e.len));
                    end
                end
                low = 0;
            end
            prev = done;
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        @(posedge clk);
        #1;
        sb.push_back('{prod: exp, len: 19});
        en           = 1'b1;
        signed_op    = s;
        multiplicand = a;
        multiplier   = b;
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] last;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_done", 64'(done), 64'd1);
        check("reset_product", {product_hi, product_lo}, 64'd0);

        // 0*0 unsigned matches the cleared last request: never started.
        @(posedge clk);
        #1 en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("zero_req_done", 64'(done), 64'd1);
        end

        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        issue(1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB);
        issue(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        issue(1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        issue(1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F);

        repeat (10) begin
            @(negedge clk);
            check("hold_done", 64'(done), 64'd1);
            check("hold_product", {product_hi, product_lo}, 64'h00000000_0000000F);
        end
        issue(1'b0, 32'h00000003, 32'h00000006, 64'h00000000_00000012);

        // Operand and en churn while ON must not disturb the result.
        @(posedge clk);
        #1;
        sb.push_back('{prod: 64'hF8CC93D6_242D2080, len: 19});
        en = 1'b1; signed_op = 1'b1;
        multiplicand = 32'h12345678; multiplier = 32'h9ABCDEF0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            multiplicand = $urandom; multiplier = $urandom;
            en = ~en; signed_op = ~signed_op;
        end
        #1 en = 1'b0;
        wait_done();

        // Reset in the 8th ON cycle abandons the operation.
        @(posedge clk);
        #1;
        sb.push_back('{prod: 64'd0, len: 9});
        en = 1'b1; signed_op = 1'b0;
        multiplicand = 32'h12345678; multiplier = 32'h9ABCDEF0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0; en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midreset_done", 64'(done), 64'd1);
        check("midreset_product", {product_hi, product_lo}, 64'd0);

        issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080);

        last = {1'b0, 32'h12345678};
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 en = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h7FFFFFFF;
                3: b = 32'h00000000;
                default: ;
            endcase
            if (s == signed_op && a == multiplicand && b == multiplier)
                a = a ^ 32'h1;
            issue(s, a, b, ref_mul(s, a, b));
        end
        if (last[0]) ;

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
